fifo_fwft_prog: RTL

//  Parametrised first-word-fall-through FIFO; successor to the shift-register FIFO in the SPI/AXI interface cores.

---
 rtl/fifo_fwft_prog_if.sv | 37 +++
 rtl/fifo_fwft_prog.sv | 116 +++++++++++
 2 files changed

// File: rtl/fifo_fwft_prog_if.sv
// FWFT FIFO bus: write/read handshake, data, thresholds, status, errors.
// master = FIFO user (drives requests/thresholds); slave = FIFO.
interface fifo_fwft_prog_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  flush;
    logic [WIDTH-1:0]      data_in;
    logic                  write;
    logic                  read;
    logic [WIDTH-1:0]      data_out;
    logic                  exists;
    logic                  full;
    logic [DEPTH_LOG2:0]   full_hi;
    logic [DEPTH_LOG2:0]   full_lo;
    logic [DEPTH_LOG2:0]   empty_thr;
    logic                  prg_full;
    logic                  prg_empty;
    logic [DEPTH_LOG2:0]   occupancy;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, write, read,
        output full_hi, full_lo, empty_thr, err_clr,
        input  data_out, exists, full, prg_full, prg_empty,
        input  occupancy, overflow, underflow
    );

    modport slave (
        input  flush, data_in, write, read,
        input  full_hi, full_lo, empty_thr, err_clr,
        output data_out, exists, full, prg_full, prg_empty,
        output occupancy, overflow, underflow
    );
endinterface

// File: rtl/fifo_fwft_prog.sv
// First-word-fall-through circular FIFO with programmable thresholds,
// flush and sticky errors. Ports: clk, rstn (sync active-low), bus (slave).
module fifo_fwft_prog #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic clk,
    input  logic rstn,
    fifo_fwft_prog_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_occ;
    logic                  r_exists;
    logic                  r_full;
    logic                  r_prg_full;
    logic                  r_prg_empty;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_rd;
    logic                  w_wr;
    logic [DEPTH_LOG2:0]   w_occ_nxt;
    logic                  w_pf_nxt;
    logic                  w_ovf_set;
    logic                  w_unf_set;

    // flush suppresses traffic and error detection for its cycle
    assign w_rd = bus.read & r_exists & ~bus.flush;
    assign w_wr = bus.write & (~r_full | bus.read) & ~bus.flush;

    assign w_ovf_set = bus.write & r_full & ~bus.read & ~bus.flush;
    assign w_unf_set = bus.read & ~r_exists & ~bus.flush;

    always_comb begin
        w_occ_nxt = r_occ;
        if (bus.flush) begin
            w_occ_nxt = '0;
        end else begin
            w_occ_nxt = r_occ + (DEPTH_LOG2 + 1)'(w_wr)
                              - (DEPTH_LOG2 + 1)'(w_rd);
        end
    end

    // hysteresis: set has priority when thresholds overlap
    always_comb begin
        w_pf_nxt = r_prg_full;
        if (w_occ_nxt >= bus.full_hi) begin
            w_pf_nxt = 1'b1;
        end else if (w_occ_nxt < bus.full_lo) begin
            w_pf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_exists    <= 1'b0;
            r_full      <= 1'b0;
            r_prg_full  <= 1'b0;
            r_prg_empty <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_prg_full <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_prg_full <= w_pf_nxt;
            end
            r_occ       <= w_occ_nxt;
            r_exists    <= (w_occ_nxt != '0);
            r_full      <= (w_occ_nxt == DEPTH_C);
            r_prg_empty <= (w_occ_nxt <= bus.empty_thr);
            // a new error event wins over a clear in the same cycle
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (bus.err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.data_out  = r_mem[r_rd_ptr];
    assign bus.exists    = r_exists;
    assign bus.full      = r_full;
    assign bus.prg_full  = r_prg_full;
    assign bus.prg_empty = r_prg_empty;
    assign bus.occupancy = r_occ;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule
